// File: rtl/port_mux_arb.sv
// Port multiplexer/arbiter between the PATLPP byte-stream link and NPORTS port modules.
// Ingress strips a port-ID header and steers the frame; egress round-robins whole frames and prepends the ID.
module port_mux_arb #(
  parameter int NPORTS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_sof,
  input  logic                  in_eof,
  input  logic                  in_src_rdy,
  output logic                  in_dst_rdy,
  output logic [7:0]            p_data,
  output logic                  p_sof,
  output logic                  p_eof,
  output logic                  p_src_rdy,
  output logic [NPORTS-1:0]     p_en,
  input  logic [NPORTS-1:0]     p_dst_rdy,
  input  logic [8*NPORTS-1:0]   po_data,
  input  logic [NPORTS-1:0]     po_sof,
  input  logic [NPORTS-1:0]     po_eof,
  input  logic [NPORTS-1:0]     po_src_rdy,
  output logic [NPORTS-1:0]     po_dst_rdy,
  output logic [7:0]            out_data,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  out_src_rdy,
  input  logic                  out_dst_rdy,
  output logic                  err_badport,
  output logic                  err_frame
);

  localparam logic [7:0] NPORTS_B = 8'(NPORTS);
  localparam logic [2:0] LAST_ID  = 3'(NPORTS - 1);

  typedef enum logic [1:0] {I_HDR, I_FWD, I_DROP} i_state_t;
  typedef enum logic [1:0] {E_IDLE, E_HDR, E_BODY} e_state_t;

  i_state_t i_state_reg, i_state_next;
  e_state_t e_state_reg, e_state_next;

  logic [2:0]        sel_reg, sel_next;
  logic              first_reg, first_next;
  logic              err_badport_reg, err_badport_next;
  logic [2:0]        grant_reg, grant_next;
  logic [2:0]        last_grant_reg, last_grant_next;
  logic              err_frame_reg, err_frame_next;

  logic [NPORTS-1:0] sel_hot;
  logic [NPORTS-1:0] grant_hot;
  logic [NPORTS-1:0] req;
  logic [7:0]        po_byte [NPORTS];
  logic [7:0]        grant_data;
  logic              in_rdy_c;
  logic [NPORTS-1:0] po_rdy_c;
  logic              found;
  logic [2:0]        pick;

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      assign sel_hot[gi]   = (sel_reg == 3'(gi));
      assign grant_hot[gi] = (grant_reg == 3'(gi));
      assign po_byte[gi]   = po_data[8*gi +: 8];
      assign req[gi]       = po_src_rdy[gi] & po_sof[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_state_reg     <= I_HDR;
      sel_reg         <= '0;
      first_reg       <= 1'b0;
      err_badport_reg <= 1'b0;
      e_state_reg     <= E_IDLE;
      grant_reg       <= '0;
      last_grant_reg  <= LAST_ID;
      err_frame_reg   <= 1'b0;
    end else begin
      i_state_reg     <= i_state_next;
      sel_reg         <= sel_next;
      first_reg       <= first_next;
      err_badport_reg <= err_badport_next;
      e_state_reg     <= e_state_next;
      grant_reg       <= grant_next;
      last_grant_reg  <= last_grant_next;
      err_frame_reg   <= err_frame_next;
    end
  end

  // Ingress: the data path is purely combinational once a port is selected.
  always_comb begin
    i_state_next     = i_state_reg;
    sel_next         = sel_reg;
    first_next       = first_reg;
    err_badport_next = err_badport_reg;
    in_rdy_c         = 1'b0;
    p_data           = '0;
    p_sof            = 1'b0;
    p_eof            = 1'b0;
    p_src_rdy        = 1'b0;
    p_en             = '0;
    case (i_state_reg)
      I_HDR: begin
        in_rdy_c = 1'b1;
        if (in_src_rdy && in_sof) begin
          if (in_data < NPORTS_B) begin
            if (!in_eof) begin
              sel_next     = in_data[2:0];
              first_next   = 1'b1;
              i_state_next = I_FWD;
            end
          end else begin
            err_badport_next = 1'b1;
            if (!in_eof) i_state_next = I_DROP;
          end
        end
      end
      I_FWD: begin
        p_data    = in_data;
        p_src_rdy = in_src_rdy;
        p_en      = sel_hot;
        p_eof     = in_eof;
        p_sof     = first_reg;
        in_rdy_c  = |(p_dst_rdy & sel_hot);
        if (in_src_rdy && in_rdy_c) begin
          first_next = 1'b0;
          if (in_eof) i_state_next = I_HDR;
        end
      end
      I_DROP: begin
        in_rdy_c = 1'b1;
        if (in_src_rdy && in_eof) i_state_next = I_HDR;
      end
      default: i_state_next = I_HDR;
    endcase
  end

  // Round-robin: ports above last_grant first, then wrap to the low IDs.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (!found && req[i] && (3'(i) > last_grant_reg)) begin
        found = 1'b1;
        pick  = 3'(i);
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (!found && req[i] && (3'(i) <= last_grant_reg)) begin
        found = 1'b1;
        pick  = 3'(i);
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NPORTS; i++) begin
      grant_data = grant_data | (po_byte[i] & {8{grant_hot[i]}});
    end
  end

  always_comb begin
    e_state_next    = e_state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    err_frame_next  = err_frame_reg;
    po_rdy_c        = '0;
    out_data        = '0;
    out_sof         = 1'b0;
    out_eof         = 1'b0;
    out_src_rdy     = 1'b0;
    case (e_state_reg)
      E_IDLE: begin
        // Stray mid-frame bytes are swallowed so they cannot block arbitration.
        po_rdy_c = po_src_rdy & ~po_sof;
        if (|po_rdy_c) err_frame_next = 1'b1;
        if (found) begin
          grant_next   = pick;
          e_state_next = E_HDR;
        end
      end
      E_HDR: begin
        out_data    = {5'b0, grant_reg};
        out_sof     = 1'b1;
        out_src_rdy = 1'b1;
        if (out_dst_rdy) e_state_next = E_BODY;
      end
      E_BODY: begin
        out_data    = grant_data;
        out_src_rdy = |(po_src_rdy & grant_hot);
        out_eof     = |(po_eof & grant_hot);
        po_rdy_c    = grant_hot & {NPORTS{out_dst_rdy}};
        if (out_src_rdy && out_dst_rdy && out_eof) begin
          last_grant_next = grant_reg;
          e_state_next    = E_IDLE;
        end
      end
      default: e_state_next = E_IDLE;
    endcase
  end

  // Ready strobes are masked during reset so nothing is accepted while it is held.
  assign in_dst_rdy  = in_rdy_c & ~rst;
  assign po_dst_rdy  = po_rdy_c & {NPORTS{~rst}};
  assign err_badport = err_badport_reg;
  assign err_frame   = err_frame_reg;

endmodule

// File: tb/tb_port_mux_arb.sv
// Self-checking bench for port_mux_arb: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_port_mux_arb;
  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      in_data = '0;
  logic            in_sof = 1'b0, in_eof = 1'b0, in_src_rdy = 1'b0;
  logic            in_dst_rdy;
  logic [7:0]      p_data;
  logic            p_sof, p_eof, p_src_rdy;
  logic [NP-1:0]   p_en;
  logic [NP-1:0]   p_dst_rdy = '1;
  logic [8*NP-1:0] po_data = '0;
  logic [NP-1:0]   po_sof = '0, po_eof = '0, po_src_rdy = '0;
  logic [NP-1:0]   po_dst_rdy;
  logic [7:0]      out_data;
  logic            out_sof, out_eof, out_src_rdy;
  logic            out_dst_rdy = 1'b1;
  logic            err_badport, err_frame;

  port_mux_arb #(.NPORTS(NP)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .in_src_rdy(in_src_rdy), .in_dst_rdy(in_dst_rdy),
    .p_data(p_data), .p_sof(p_sof), .p_eof(p_eof), .p_src_rdy(p_src_rdy),
    .p_en(p_en), .p_dst_rdy(p_dst_rdy),
    .po_data(po_data), .po_sof(po_sof), .po_eof(po_eof),
    .po_src_rdy(po_src_rdy), .po_dst_rdy(po_dst_rdy),
    .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .out_src_rdy(out_src_rdy), .out_dst_rdy(out_dst_rdy),
    .err_badport(err_badport), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Observation state, sampled on the falling edge.
  logic [13:0]   p_rec[$];
  logic [13:0]   exp_p[$];
  logic [9:0]    out_rec[$];
  logic [9:0]    exp_o[$];
  logic [NP-1:0] pen_seen = '0;
  int            psrc_cnt = 0, en_bad = 0, in_stall = 0, in_timeouts = 0;
  int            mirror_bad = 0;
  bit            track_mirror = 0;

  // Port response model storage.
  logic [9:0] pmem [NP][256];
  int         phead[NP], ptail[NP], pstart[NP];
  bit         po_acc[NP];
  bit         po_gaps = 0;
  int         odr_mode = 0;
  int         rdy_mode = 0;
  int         stall_left = 0;
  logic [7:0] fb[$];

  initial begin
    for (int i = 0; i < NP; i++) begin
      phead[i] = 0; ptail[i] = 0; pstart[i] = 0; po_acc[i] = 0;
    end
  end

  always @(negedge clk) begin
    int pidx;
    if (p_src_rdy && |(p_en & p_dst_rdy)) begin
      pidx = 0;
      for (int i = 0; i < NP; i++) if (p_en[i]) pidx = i;
      p_rec.push_back({4'(pidx), p_sof, p_eof, p_data});
    end
    if (p_src_rdy) begin
      psrc_cnt++;
      pen_seen = pen_seen | p_en;
      if (!$onehot(p_en)) en_bad++;
    end
    if (in_src_rdy && !in_dst_rdy) in_stall++;
    if (out_src_rdy && out_dst_rdy) out_rec.push_back({out_sof, out_eof, out_data});
    for (int i = 0; i < NP; i++) if (po_src_rdy[i] && po_dst_rdy[i]) po_acc[i] = 1;
    if (track_mirror) begin
      if (out_src_rdy && !out_sof) begin
        if (po_dst_rdy[1] !== out_dst_rdy) mirror_bad++;
      end else if (po_dst_rdy[1]) mirror_bad++;
    end
  end

  // Port-side ready pattern, applied after the stimulus has settled.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: p_dst_rdy = '1;
      1: p_dst_rdy = NP'($urandom);
      2: if (p_en[2] && p_src_rdy && p_data == 8'hBB && stall_left > 0) begin
           p_dst_rdy = 4'b1011;
           stall_left--;
         end else p_dst_rdy = '1;
      default: p_dst_rdy = '0;
    endcase
  end

  // Response ports replay their stored frames; out_dst_rdy follows odr_mode.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NP; i++) begin
      if (po_acc[i]) begin
        phead[i]++;
        po_acc[i] = 0;
      end
      if (phead[i] < ptail[i] && !(po_gaps && $urandom_range(0, 3) == 0)) begin
        po_src_rdy[i]        = 1'b1;
        po_sof[i]            = pmem[i][phead[i]][9];
        po_eof[i]            = pmem[i][phead[i]][8];
        po_data[8*i +: 8]    = pmem[i][phead[i]][7:0];
      end else begin
        po_src_rdy[i] = 1'b0;
        po_sof[i]     = 1'b0;
        po_eof[i]     = 1'b0;
      end
    end
    case (odr_mode)
      0: out_dst_rdy = 1'b1;
      1: out_dst_rdy = ~out_dst_rdy;
      2: out_dst_rdy = 1'($urandom_range(0, 1));
      default: out_dst_rdy = 1'b0;
    endcase
  end

  task automatic drive_byte(input logic [7:0] d, input logic s, input logic e, input bit gaps);
    int budget;
    bit acc;
    if (gaps) while ($urandom_range(0, 3) == 0) begin
      in_src_rdy = 1'b0;
      @(posedge clk); #1;
    end
    in_data = d; in_sof = s; in_eof = e; in_src_rdy = 1'b1;
    budget = 500;
    acc = 0;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = in_dst_rdy;
      @(posedge clk); #1;
      budget--;
    end
    if (!acc) in_timeouts++;
    in_src_rdy = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input bit gaps);
    drive_byte(hdr, 1'b1, fb.size() == 0, gaps);
    foreach (fb[k]) drive_byte(fb[k], 1'b0, k == fb.size() - 1, gaps);
  endtask

  // Reference: a valid ID with payload delivers the payload to that port, sof first, eof last.
  task automatic model_frame(input logic [7:0] hdr);
    if (hdr < NP && fb.size() > 0)
      foreach (fb[k]) exp_p.push_back({4'(hdr), k == 0, k == fb.size() - 1, fb[k]});
  endtask

  task automatic check_ingress(input string tag);
    int errs = 0;
    chk({tag, "_count"}, p_rec.size(), exp_p.size());
    foreach (exp_p[k]) if (k >= p_rec.size() || p_rec[k] !== exp_p[k]) errs++;
    chk({tag, "_bytes"}, errs, 0);
    p_rec.delete();
    exp_p.delete();
  endtask

  task automatic check_out(input string tag);
    int errs = 0;
    chk({tag, "_count"}, out_rec.size(), exp_o.size());
    foreach (exp_o[k]) if (k >= out_rec.size() || out_rec[k] !== exp_o[k]) errs++;
    chk({tag, "_bytes"}, errs, 0);
    out_rec.delete();
    exp_o.delete();
  endtask

  task automatic load_frame(input int p, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      pmem[p][ptail[p]] = {k == 0, k == len - 1, base + 8'(k)};
      ptail[p]++;
    end
  endtask

  // Expected egress: header byte (sof, ID) then that port's next frame verbatim.
  task automatic expect_frame(input int p, input int len, input logic [7:0] base);
    exp_o.push_back({1'b1, 1'b0, 8'(p)});
    for (int k = 0; k < len; k++) exp_o.push_back({1'b0, k == len - 1, base + 8'(k)});
  endtask

  function automatic bit ports_empty();
    for (int i = 0; i < NP; i++) if (phead[i] < ptail[i]) return 0;
    return 1;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!ports_empty() && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_drained"}, ports_empty(), 1);
  endtask

  task automatic check_egress(input string tag);
    int ptr[NP];
    int errs = 0;
    int cur = -1;
    int left = 0;
    bit first = 0;
    logic [9:0] e;
    for (int i = 0; i < NP; i++) ptr[i] = pstart[i];
    foreach (out_rec[k]) begin
      if (cur < 0) begin
        if (!out_rec[k][9] || out_rec[k][7:0] >= NP) errs++;
        else begin
          cur   = int'(out_rec[k][7:0]);
          first = 1;
        end
      end else begin
        if (out_rec[k][9] || ptr[cur] >= ptail[cur]) errs++;
        else begin
          e = pmem[cur][ptr[cur]];
          if (out_rec[k][8] !== e[8] || out_rec[k][7:0] !== e[7:0] || e[9] !== first) errs++;
          ptr[cur]++;
        end
        first = 0;
        if (out_rec[k][8]) cur = -1;
      end
    end
    chk({tag, "_frames"}, errs, 0);
    for (int i = 0; i < NP; i++) left += ptail[i] - ptr[i];
    chk({tag, "_all_delivered"}, left, 0);
    out_rec.delete();
  endtask

  initial begin
    int budget;
    logic [7:0] hdr;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {in_dst_rdy, p_src_rdy, p_sof, p_eof, p_en, po_dst_rdy, out_src_rdy, out_sof, out_eof,
         err_badport, err_frame, p_data, out_data}, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_dst_rdy", in_dst_rdy, 1'b1);

    // Basic forward to port 2.
    pen_seen = '0;
    fb = {8'hAA, 8'hBB, 8'hCC};
    model_frame(8'h02);
    send_frame(8'h02, 0);
    repeat (2) @(posedge clk);
    #1;
    check_ingress("ing_basic");
    chk("ing_basic_p_en_seen", pen_seen, 4'b0100);

    // Port 2 holds off BB for three cycles.
    rdy_mode = 2; stall_left = 3; in_stall = 0;
    fb = {8'hAA, 8'hBB, 8'hCC};
    model_frame(8'h02);
    send_frame(8'h02, 0);
    repeat (2) @(posedge clk);
    #1;
    rdy_mode = 0;
    chk("ing_stall_cycles", in_stall, 3);
    check_ingress("ing_stall");

    // Bad port ID: whole frame dropped, then normal traffic resumes.
    budget = psrc_cnt;
    fb = {8'h11, 8'h22};
    send_frame(8'h07, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("badport_flag", err_badport, 1'b1);
    chk("badport_no_forward", psrc_cnt - budget, 0);
    chk("badport_consumed", in_timeouts, 0);
    fb = {8'h55};
    model_frame(8'h01);
    send_frame(8'h01, 0);
    repeat (2) @(posedge clk);
    #1;
    check_ingress("ing_after_bad");

    // Egress: simultaneous requests from ports 0 and 3.
    odr_mode = 0;
    out_rec.delete();
    load_frame(0, 2, 8'h10);
    load_frame(3, 2, 8'h30);
    expect_frame(0, 2, 8'h10);
    expect_frame(3, 2, 8'h30);
    drain("egr_pair1", 200);
    check_out("egr_pair1");
    load_frame(0, 2, 8'h50);
    load_frame(3, 2, 8'h70);
    expect_frame(0, 2, 8'h50);
    expect_frame(3, 2, 8'h70);
    drain("egr_pair2", 200);
    check_out("egr_pair2");

    // Backpressure toggling on every cycle during a port 1 frame.
    odr_mode = 1; mirror_bad = 0; track_mirror = 1;
    load_frame(1, 5, 8'hA0);
    expect_frame(1, 5, 8'hA0);
    drain("egr_toggle", 200);
    track_mirror = 0;
    odr_mode = 0;
    check_out("egr_toggle");
    chk("egr_toggle_mirror", mirror_bad, 0);

    // Randomized traffic in both directions at once.
    for (int i = 0; i < NP; i++) pstart[i] = ptail[i];
    out_rec.delete();
    odr_mode = 2; po_gaps = 1; rdy_mode = 1; en_bad = 0;
    for (int f = 0; f < 6; f++)
      for (int p = 0; p < NP; p++) load_frame(p, $urandom_range(1, 5), 8'($urandom));
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) drive_byte(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1);
      hdr = 8'($urandom_range(0, 5));
      fb.delete();
      for (int k = $urandom_range(0, 5); k > 0; k--) fb.push_back(8'($urandom));
      model_frame(hdr);
      send_frame(hdr, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check_ingress("ing_rand");
    chk("ing_rand_onehot", en_bad, 0);
    chk("ing_rand_timeouts", in_timeouts, 0);
    drain("egr_rand", 5000);
    check_egress("egr_rand");
    chk("egr_rand_no_err_frame", err_frame, 1'b0);
    odr_mode = 0; po_gaps = 0; rdy_mode = 3;

    // Reset in mid-frame on both sides.
    out_rec.delete();
    load_frame(2, 8, 8'hC0);
    drive_byte(8'h01, 1'b1, 1'b0, 0);
    in_data = 8'hD1; in_src_rdy = 1'b1;
    budget = 100;
    while (out_rec.size() < 3 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("pre_rst_active", {p_src_rdy, out_src_rdy}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs",
        {in_dst_rdy, p_src_rdy, p_sof, p_eof, p_en, po_dst_rdy, out_src_rdy, out_sof, out_eof,
         err_badport, err_frame, p_data, out_data}, 64'h0);
    in_src_rdy = 1'b0; in_data = '0;
    for (int i = 0; i < NP; i++) phead[i] = ptail[i];
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    p_rec.delete(); exp_p.delete(); out_rec.delete();
    @(posedge clk); #1;
    fb = {8'h9A};
    model_frame(8'h00);
    send_frame(8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    check_ingress("ing_post_rst");
    chk("post_rst_badport_clear", err_badport, 1'b0);
    load_frame(3, 2, 8'h80);
    load_frame(0, 2, 8'h90);
    expect_frame(0, 2, 8'h90);
    expect_frame(3, 2, 8'h80);
    drain("egr_post_rst", 200);
    check_out("egr_post_rst");

    // Stray non-sof byte while egress is idle.
    pmem[2][ptail[2]] = {1'b0, 1'b0, 8'hEE};
    ptail[2]++;
    drain("egr_stray", 50);
    chk("err_frame_set", err_frame, 1'b1);
    chk("egr_stray_no_output", out_rec.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
